// File: rtl/sram_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sram_ctrl_pkg
// Description : Shared types and widths for the 32-bit to 16-bit async SRAM
//               controller: FSM state encoding and datapath widths.
// Revision    : 1.0 - initial release
// ============================================================================
package sram_ctrl_pkg;

    localparam int SRAM_DW     = 16;  // external SRAM data width
    localparam int WORD_W      = 32;  // pipeline word width
    localparam int PHASE_CNT_W = 4;   // phase counter width (WAIT_CYCLES <= 15)

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RD_LO = 3'd1,
        ST_RD_HI = 3'd2,
        ST_WR_LO = 3'd3,
        ST_WR_HI = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

endpackage : sram_ctrl_pkg
`default_nettype wire

// File: rtl/sram_phase_counter.sv
`default_nettype none
// ============================================================================
// Module      : sram_phase_counter
// Description : Down-counter timing one half-word SRAM phase. Loaded with
//               WAIT_CYCLES-1 on phase entry, decrements to 0 and holds there.
//               'last' flags the final cycle of the phase.
// Ports       : clk, rst_n     - clock, async active-low reset
//               load, load_val - reload request and value
//               last           - counter is 0 (phase ends this cycle)
// Revision    : 1.0 - initial release
// ============================================================================
module sram_phase_counter
    import sram_ctrl_pkg::*;
#(
    parameter int CNT_W = PHASE_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             last
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= load_val;
        end else if (r_count != '0) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign last = (r_count == '0);

endmodule : sram_phase_counter
`default_nettype wire

// File: rtl/sram_controller.sv
`default_nettype none
// ============================================================================
// Module      : sram_controller
// Description : Sequences 32-bit MEM-stage loads/stores onto a 16-bit async
//               SRAM as two half-word phases (low half at even address, high
//               half at odd). mem_ready stalls the pipeline while busy.
// Ports       : clk, rst_n           - clock, async active-low reset
//               wr_en, rd_en, addr,
//               wdata                - request from MEM stage
//               rdata, mem_ready     - load data and stall release
//               sram_*               - external SRAM bus and strobes
// Option      : SRAM_CTRL_STATS_EN adds rd_count/wr_count completion counters.
// Revision    : 1.0 - initial release
// ============================================================================
module sram_controller
    import sram_ctrl_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'd1024,
    parameter int          WAIT_CYCLES = 2,
    parameter int          SRAM_AW     = 18
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                wr_en,
    input  logic                rd_en,
    input  logic [WORD_W-1:0]   addr,
    input  logic [WORD_W-1:0]   wdata,
    output logic [WORD_W-1:0]   rdata,
    output logic                mem_ready,
    inout  wire  [SRAM_DW-1:0]  sram_dq,
    output logic [SRAM_AW-1:0]  sram_addr,
    output logic                sram_we_n,
    output logic                sram_oe_n,
    output logic                sram_ce_n,
    output logic                sram_ub_n,
    output logic                sram_lb_n
`ifdef SRAM_CTRL_STATS_EN
    ,
    output logic [15:0]         rd_count,
    output logic [15:0]         wr_count
`endif
);

    localparam logic [PHASE_CNT_W-1:0] c_phase_load = PHASE_CNT_W'(WAIT_CYCLES - 1);

    state_t               r_state;
    state_t               w_next;
    logic [SRAM_AW-2:0]   r_word_addr;
    logic [WORD_W-1:0]    r_wdata;
    logic [WORD_W-1:0]    r_rdata;
    logic [WORD_W-1:0]    w_off;
    logic                 w_unused_off_bits;
    logic                 w_launch;
    logic                 w_last;
    logic                 w_cnt_load;
    logic                 w_phase_next;
    logic                 w_half;
    logic                 w_dq_oe;
    logic [SRAM_DW-1:0]   w_dq_out;

    // Word offset into the SRAM; byte-lane bits and bits above the SRAM
    // range are dropped.
    assign w_off             = addr - BASE_ADDR;
    assign w_unused_off_bits = ^{w_off[WORD_W-1:SRAM_AW+1], w_off[1:0]};
    assign w_launch          = (r_state == ST_IDLE) && (wr_en || rd_en);

    sram_phase_counter #(.CNT_W(PHASE_CNT_W)) u_phase_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (w_cnt_load),
        .load_val (c_phase_load),
        .last     (w_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        mem_ready = 1'b0;
        sram_ce_n = 1'b1;
        sram_ub_n = 1'b1;
        sram_lb_n = 1'b1;
        sram_oe_n = 1'b1;
        sram_we_n = 1'b1;
        unique case (r_state)
            ST_IDLE: begin
                mem_ready = !(wr_en || rd_en);
                if (wr_en) begin
                    w_next = ST_WR_LO;   // write wins when both are raised
                end else if (rd_en) begin
                    w_next = ST_RD_LO;
                end
            end
            ST_RD_LO, ST_RD_HI: begin
                sram_ce_n = 1'b0;
                sram_ub_n = 1'b0;
                sram_lb_n = 1'b0;
                sram_oe_n = 1'b0;
                if (w_last) begin
                    w_next = (r_state == ST_RD_LO) ? ST_RD_HI : ST_DONE;
                end
            end
            ST_WR_LO, ST_WR_HI: begin
                sram_ce_n = 1'b0;
                sram_ub_n = 1'b0;
                sram_lb_n = 1'b0;
                sram_we_n = 1'b0;
                if (w_last) begin
                    w_next = (r_state == ST_WR_LO) ? ST_WR_HI : ST_DONE;
                end
            end
            ST_DONE: begin
                // Always pass through IDLE so the still-held request cannot
                // relaunch before the pipeline has advanced.
                mem_ready = 1'b1;
                w_next    = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // Reload the phase counter on every entry into a new phase state.
    assign w_phase_next = (w_next == ST_RD_LO) || (w_next == ST_RD_HI) ||
                          (w_next == ST_WR_LO) || (w_next == ST_WR_HI);
    assign w_cnt_load   = w_phase_next && (w_next != r_state);

    // Request is latched at launch so protocol violations cannot corrupt
    // an access in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_word_addr <= '0;
            r_wdata     <= '0;
        end else if (w_launch) begin
            r_word_addr <= w_off[SRAM_AW:2];
            r_wdata     <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdata <= '0;
        end else if (w_last && (r_state == ST_RD_LO)) begin
            r_rdata[SRAM_DW-1:0] <= sram_dq;
        end else if (w_last && (r_state == ST_RD_HI)) begin
            r_rdata[WORD_W-1:SRAM_DW] <= sram_dq;
        end
    end

    assign rdata     = r_rdata;
    assign w_half    = (r_state == ST_RD_HI) || (r_state == ST_WR_HI);
    assign sram_addr = {r_word_addr, w_half};
    assign w_dq_oe   = (r_state == ST_WR_LO) || (r_state == ST_WR_HI);
    assign w_dq_out  = (r_state == ST_WR_HI) ? r_wdata[WORD_W-1:SRAM_DW]
                                             : r_wdata[SRAM_DW-1:0];
    assign sram_dq   = w_dq_oe ? w_dq_out : {SRAM_DW{1'bz}};

`ifdef SRAM_CTRL_STATS_EN
    logic [15:0] r_rd_count;
    logic [15:0] r_wr_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_count <= '0;
            r_wr_count <= '0;
        end else if (w_next == ST_DONE) begin
            if (r_state == ST_RD_HI) begin
                r_rd_count <= r_rd_count + 16'd1;
            end
            if (r_state == ST_WR_HI) begin
                r_wr_count <= r_wr_count + 16'd1;
            end
        end
    end

    assign rd_count = r_rd_count;
    assign wr_count = r_wr_count;
`endif

endmodule : sram_controller
`default_nettype wire

// File: tb/tb_sram_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_sram_controller
// Description : Self-checking bench for sram_controller. A word-level
//               reference model predicts every cycle of each access; an
//               async SRAM model answers the bus. Directed cases first,
//               then randomized accesses.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sram_controller;

    localparam int WC = 2;
    localparam int AW = 18;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          wr_en = 1'b0;
    logic          rd_en = 1'b0;
    logic [31:0]   addr  = '0;
    logic [31:0]   wdata = '0;
    wire  [31:0]   rdata;
    wire           mem_ready;
    wire  [15:0]   sram_dq;
    wire  [AW-1:0] sram_addr;
    wire           sram_we_n, sram_oe_n, sram_ce_n, sram_ub_n, sram_lb_n;
`ifdef SRAM_CTRL_STATS_EN
    wire  [15:0]   rd_count;
    wire  [15:0]   wr_count;
`endif

    sram_controller #(
        .BASE_ADDR   (32'd1024),
        .WAIT_CYCLES (WC),
        .SRAM_AW     (AW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (wr_en),
        .rd_en     (rd_en),
        .addr      (addr),
        .wdata     (wdata),
        .rdata     (rdata),
        .mem_ready (mem_ready),
        .sram_dq   (sram_dq),
        .sram_addr (sram_addr),
        .sram_we_n (sram_we_n),
        .sram_oe_n (sram_oe_n),
        .sram_ce_n (sram_ce_n),
        .sram_ub_n (sram_ub_n),
        .sram_lb_n (sram_lb_n)
`ifdef SRAM_CTRL_STATS_EN
        ,
        .rd_count  (rd_count),
        .wr_count  (wr_count)
`endif
    );

    always #5 clk = ~clk;

    // ---------------- async SRAM model ----------------
    logic [15:0] sram_mem [0:255];
    bit          written  [0:255];
    logic [15:0] sram_rd_val;
    logic [7:0]  sram_idx;

    function automatic logic [15:0] init_val(input int a);
        return 16'((a * 32'h1357) ^ 32'hA5A5);
    endfunction

    assign sram_idx = sram_addr[7:0];
    always_comb begin
        sram_rd_val = written[sram_idx] ? sram_mem[sram_idx] : init_val(int'(sram_idx));
    end
    assign sram_dq = (!sram_ce_n && !sram_oe_n && sram_we_n) ? sram_rd_val : 16'bz;

    always @(posedge clk) begin
        if (!sram_ce_n && !sram_we_n) begin
            sram_mem[sram_idx] <= sram_dq;
            written[sram_idx]  <= 1'b1;
        end
    end

    // ---------------- reference model ----------------
    typedef struct {
        bit          rdy;
        bit [4:0]    strb;      // {ce_n, oe_n, we_n, ub_n, lb_n}
        bit          chk_addr;
        logic [17:0] a;
        int          dqmode;    // 0 released, 1 driven value, 2 SRAM drives
        logic [15:0] dq;
        bit          chk_rd;
        logic [31:0] rd;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] ref_words [int];
    logic [31:0] exp_rdata = '0;
    int          exp_rd_cnt = 0;
    int          exp_wr_cnt = 0;
    int          n_chk  = 0;
    int          n_fail = 0;

    function automatic logic [31:0] ref_read(input int w);
        if (ref_words.exists(w)) return ref_words[w];
        return {init_val(2 * w + 1), init_val(2 * w)};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
        n_chk++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp_v, $time);
        end
    endtask

    task automatic chk_rel(input string nm, input logic [15:0] v);
        n_chk++;
        if (!((v === 16'hzzzz) || (v === 16'h0000))) begin
            n_fail++;
            $display("FAIL %s: got %h expected released bus at %0t", nm, v, $time);
        end
    endtask

    // Per-cycle compare against the predicted expectation stream.
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("mem_ready", mem_ready, e.rdy);
            chk("strobes", {sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n}, e.strb);
            if (e.chk_addr)         chk("sram_addr", sram_addr, e.a);
            if (e.dqmode == 1)      chk("dq_drive", sram_dq, e.dq);
            else if (e.dqmode == 0) chk_rel("dq_release", sram_dq);
            if (e.chk_rd)           chk("rdata", rdata, e.rd);
        end
    end

    function automatic exp_t quiet_entry(input bit rdy);
        exp_t e;
        e.rdy = rdy; e.strb = 5'h1f; e.chk_addr = 1'b0; e.a = '0;
        e.dqmode = 0; e.dq = '0; e.chk_rd = 1'b1; e.rd = exp_rdata;
        return e;
    endfunction

    // op: 0 read, 1 write, 2 both (write expected). Called just after a
    // rising edge; returns just after the edge that leaves DONE with the
    // request still held. 'low' counts cycles seen with mem_ready low.
    task automatic access(input int op, input logic [31:0] a, input logic [31:0] d,
                          output int low);
        logic [31:0] off;
        logic [16:0] w;
        exp_t        e;
        bit          is_wr;
        is_wr = (op != 0);
        wr_en = is_wr;
        rd_en = (op != 1);
        addr  = a;
        wdata = d;
        off   = a - 32'd1024;
        w     = off[18:2];
        exp_q.push_back(quiet_entry(1'b0));
        for (int h = 0; h < 2; h++) begin
            for (int c = 0; c < WC; c++) begin
                e.rdy      = 1'b0;
                e.strb     = is_wr ? 5'b01000 : 5'b00100;
                e.chk_addr = 1'b1;
                e.a        = {w, h[0]};
                e.dqmode   = is_wr ? 1 : 2;
                e.dq       = (h == 1) ? d[31:16] : d[15:0];
                e.chk_rd   = 1'b0;
                e.rd       = '0;
                exp_q.push_back(e);
            end
        end
        if (is_wr) begin
            ref_words[int'(w)] = d;
            exp_wr_cnt++;
        end else begin
            exp_rdata = ref_read(int'(w));
            exp_rd_cnt++;
        end
        exp_q.push_back(quiet_entry(1'b1));
        low = 0;
        for (int i = 0; i < 2 * WC + 2; i++) begin
            @(negedge clk);
            if (!mem_ready) low++;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idle_cyc();
        wr_en = 1'b0;
        rd_en = 1'b0;
        exp_q.push_back(quiet_entry(1'b1));
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int low;
        int w;
        repeat (3) @(posedge clk);
        #1;
        // Reset state
        chk("rst_mem_ready", mem_ready, 1'b1);
        chk("rst_strobes", {sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n}, 5'h1f);
        chk("rst_sram_addr", sram_addr, 18'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk_rel("rst_dq", sram_dq);
        rst_n = 1'b1;

        // Directed write, then read back
        access(1, 32'd1024 + 32'd8, 32'hDEADBEEF, low);
        chk("wr_low_cycles", low, 5);
        chk("sram_lo_word", sram_mem[4], 16'hBEEF);
        chk("sram_hi_word", sram_mem[5], 16'hDEAD);
        access(0, 32'd1024 + 32'd8, 32'h0, low);
        chk("rd_low_cycles", low, 5);
        chk("rd_deadbeef", rdata, 32'hDEADBEEF);

        // Back-to-back: request swapped in the IDLE right after DONE
        access(0, 32'd1024 + 32'd12, 32'h0, low);
        chk("b2b_low_cycles", low, 5);
        idle_cyc();
        idle_cyc();

        // Both requests raised: write only
        access(2, 32'd1024, 32'h1234_5678, low);
        idle_cyc();
        access(0, 32'd1024, 32'h0, low);
        chk("both_readback", rdata, 32'h1234_5678);
        idle_cyc();

        // Reset during RD_HI
        rd_en = 1'b1;
        addr  = 32'd1024 + 32'd16;
        repeat (WC + 1) @(posedge clk);
        #2;
        chk("pre_rst_oe", sram_oe_n, 1'b0);
        rst_n = 1'b0;
        rd_en = 1'b0;
        #1;
        chk("arst_strobes", {sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n}, 5'h1f);
        chk("arst_mem_ready", mem_ready, 1'b1);
        chk("arst_sram_addr", sram_addr, 18'd0);
        chk("arst_rdata", rdata, 32'd0);
        chk_rel("arst_dq", sram_dq);
        exp_rdata  = '0;
        exp_rd_cnt = 0;
        exp_wr_cnt = 0;
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        access(0, 32'd1024 + 32'd16, 32'h0, low);
        chk("post_rst_low_cycles", low, 5);

        // Randomized traffic
        for (int i = 0; i < 40; i++) begin
            w = int'($urandom_range(0, 63));
            access(int'($urandom_range(0, 2)),
                   32'd1024 + 32'(w * 4) + 32'($urandom_range(0, 3)),
                   $urandom, low);
            if ($urandom_range(0, 3) == 0) idle_cyc();
        end
        idle_cyc();
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
        chk("queue_drained", exp_q.size(), 0);

`ifdef SRAM_CTRL_STATS_EN
        chk("rd_count", rd_count, 16'(exp_rd_cnt));
        chk("wr_count", wr_count, 16'(exp_wr_cnt));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule : tb_sram_controller
`default_nettype wire
